// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider / tick generator with shadowed,
// wrap-aligned reconfiguration and a global phase-align strobe.
module multi_clock_divider #(
    parameter int               NUM_CH    = 4,
    parameter int               CNT_W     = 32,
    parameter logic [CNT_W-1:0] RESET_DIV = 32'd49_999_999,
    localparam int              CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    // Writes addressed beyond the last channel are dropped here.
    logic cfg_ok;
    assign cfg_ok = cfg_we && ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] act_div_reg;
            logic [CNT_W-1:0] sh_div_reg;
            logic             act_mode_reg;
            logic             sh_mode_reg;
            logic             pend_reg;
            logic             div_reg;
            logic             tick_reg;
            logic             wr_hit;
            logic             restart;
            logic             wrap;
            logic             apply;

            assign wr_hit  = cfg_ok && (cfg_ch == CH_W'(gi));
            assign restart = sync || !en[gi];
            assign wrap    = (cnt_reg == act_div_reg);
            // The shadow only takes effect at a period boundary (or when idle),
            // so no output period is ever truncated or stretched.
            assign apply   = pend_reg && (restart || wrap);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sh_div_reg  <= RESET_DIV;
                    sh_mode_reg <= 1'b0;
                    pend_reg    <= 1'b0;
                end else if (wr_hit) begin
                    sh_div_reg  <= cfg_div;
                    sh_mode_reg <= cfg_mode;
                    pend_reg    <= 1'b1;
                end else if (apply) begin
                    pend_reg    <= 1'b0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg      <= '0;
                    act_div_reg  <= RESET_DIV;
                    act_mode_reg <= 1'b0;
                    div_reg      <= 1'b0;
                    tick_reg     <= 1'b0;
                end else begin
                    if (apply) begin
                        act_div_reg  <= sh_div_reg;
                        act_mode_reg <= sh_mode_reg;
                    end
                    if (restart) begin
                        cnt_reg  <= '0;
                        div_reg  <= 1'b0;
                        tick_reg <= 1'b0;
                    end else if (wrap) begin
                        cnt_reg  <= '0;
                        tick_reg <= 1'b1;
                        // Wrap output follows the old mode unless the mode flips now.
                        if (apply && (sh_mode_reg != act_mode_reg))
                            div_reg <= 1'b0;
                        else if (act_mode_reg)
                            div_reg <= 1'b1;
                        else
                            div_reg <= ~div_reg;
                    end else begin
                        cnt_reg  <= cnt_reg + 1'b1;
                        tick_reg <= 1'b0;
                        if (act_mode_reg)
                            div_reg <= 1'b0;
                    end
                end
            end

            assign div_out[gi] = div_reg;
            assign tick[gi]    = tick_reg;
            assign pending[gi] = pend_reg;
        end
    endgenerate

endmodule
